// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/interrupt sequencer for the 5-stage pipeline.
// Resolves data hazards, arbitrates redirects and runs interrupt entry/return.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] VECTOR_PC    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_idx_i,
  input  logic [4:0]  id_rs2_idx_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic        id_is_jalr_i,
  input  logic [31:0] id_pc_i,
  input  logic        id_taken_i,
  input  logic [4:0]  ex_rd_idx_i,
  input  logic        ex_reg_write_en_i,
  input  logic        ex_is_load_i,
  input  logic        ex_mispredict_i,
  input  logic [31:0] ex_target_i,
  input  logic [4:0]  mem_rd_idx_i,
  input  logic        mem_reg_write_en_i,
  input  logic        irq_i,
  input  logic        mret_i,
  output logic        if_enable_o,
  output logic        id_enable_o,
  output logic        if_flush_n_o,
  output logic        id_flush_n_o,
  output logic        rs1_depended_o,
  output logic        irq_redirect_o,
  output logic [31:0] irq_target_o,
  output logic        irq_ack_o,
  output logic        in_handler_o
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StRun,
    StDrain,
    StVector,
    StHandler,
    StReturn
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     epc_q, epc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     irq_target_q;

  logic ex_rd_nz;
  logic rs1_hit_ex;
  logic rs2_hit_ex;
  logic rs1_hit_mem;
  logic load_use;
  logic jalr_stall;
  logic hazard_stall;

  // Hazard detection; writes to x0 never create a dependency.
  always_comb begin
    ex_rd_nz     = (ex_rd_idx_i != 5'd0);
    rs1_hit_ex   = ex_rd_nz && (id_rs1_idx_i == ex_rd_idx_i);
    rs2_hit_ex   = ex_rd_nz && (id_rs2_idx_i == ex_rd_idx_i);
    rs1_hit_mem  = (mem_rd_idx_i != 5'd0) && (id_rs1_idx_i == mem_rd_idx_i);
    load_use     = ex_is_load_i && ex_reg_write_en_i &&
                   ((id_uses_rs1_i && rs1_hit_ex) || (id_uses_rs2_i && rs2_hit_ex));
    jalr_stall   = id_is_jalr_i && ex_is_load_i && ex_reg_write_en_i && rs1_hit_ex;
    hazard_stall = load_use || jalr_stall;
    rs1_depended_o = id_is_jalr_i && (id_rs1_idx_i != 5'd0) &&
                     ((ex_reg_write_en_i && rs1_hit_ex) ||
                      (mem_reg_write_en_i && rs1_hit_mem));
  end

  // Pipeline register control, highest priority first.
  always_comb begin
    if_enable_o  = 1'b1;
    id_enable_o  = 1'b1;
    if_flush_n_o = 1'b1;
    id_flush_n_o = 1'b1;
    if (ex_mispredict_i) begin
      if_flush_n_o = 1'b0;
      id_flush_n_o = 1'b0;
    end else if (state_q == StDrain) begin
      if_enable_o  = 1'b0;
      if_flush_n_o = 1'b0;
      id_flush_n_o = 1'b0;
    end else if (state_q == StVector) begin
      if_flush_n_o = 1'b0;
    end else if (state_q == StReturn) begin
      if_flush_n_o = 1'b0;
      id_flush_n_o = 1'b0;
    end else if (hazard_stall) begin
      if_enable_o  = 1'b0;
      id_flush_n_o = 1'b0;
    end else if (id_taken_i) begin
      if_flush_n_o = 1'b0;
    end
  end

  // Redirect outputs; the target holds its last driven value between redirects.
  always_comb begin
    irq_redirect_o = 1'b0;
    irq_ack_o      = 1'b0;
    irq_target_o   = irq_target_q;
    in_handler_o   = (state_q == StHandler);
    unique case (state_q)
      StVector: begin
        irq_redirect_o = 1'b1;
        irq_ack_o      = 1'b1;
        irq_target_o   = VECTOR_PC;
      end
      StReturn: begin
        irq_redirect_o = 1'b1;
        irq_target_o   = epc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (irq_i && !ex_mispredict_i && !hazard_stall && !id_taken_i) begin
          epc_d   = id_pc_i;
          cnt_d   = CntInit;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // A resolving mispredict means the saved pc was on the wrong path.
        if (ex_mispredict_i) begin
          epc_d = ex_target_i;
        end
        if (cnt_q == '0) begin
          state_d = StVector;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StVector: state_d = StHandler;
      StHandler: begin
        if (mret_i && !hazard_stall && !ex_mispredict_i) begin
          state_d = StReturn;
        end
      end
      StReturn: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      epc_q        <= '0;
      cnt_q        <= '0;
      irq_target_q <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cnt_q        <= cnt_d;
      irq_target_q <= irq_target_o;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs are queued as
// each step is driven and checked at the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1_idx_i;
  logic [4:0]  id_rs2_idx_i;
  logic        id_uses_rs1_i;
  logic        id_uses_rs2_i;
  logic        id_is_jalr_i;
  logic [31:0] id_pc_i;
  logic        id_taken_i;
  logic [4:0]  ex_rd_idx_i;
  logic        ex_reg_write_en_i;
  logic        ex_is_load_i;
  logic        ex_mispredict_i;
  logic [31:0] ex_target_i;
  logic [4:0]  mem_rd_idx_i;
  logic        mem_reg_write_en_i;
  logic        irq_i;
  logic        mret_i;
  logic        if_enable_o;
  logic        id_enable_o;
  logic        if_flush_n_o;
  logic        id_flush_n_o;
  logic        rs1_depended_o;
  logic        irq_redirect_o;
  logic [31:0] irq_target_o;
  logic        irq_ack_o;
  logic        in_handler_o;

  typedef struct packed {
    logic        ife;
    logic        ide;
    logic        iffn;
    logic        idfn;
    logic        rs1d;
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic        inh;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(2),
    .VECTOR_PC   (32'h0000_0100)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
    .id_rs1_idx_i      (id_rs1_idx_i),
    .id_rs2_idx_i      (id_rs2_idx_i),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .id_is_jalr_i      (id_is_jalr_i),
    .id_pc_i           (id_pc_i),
    .id_taken_i        (id_taken_i),
    .ex_rd_idx_i       (ex_rd_idx_i),
    .ex_reg_write_en_i (ex_reg_write_en_i),
    .ex_is_load_i      (ex_is_load_i),
    .ex_mispredict_i   (ex_mispredict_i),
    .ex_target_i       (ex_target_i),
    .mem_rd_idx_i      (mem_rd_idx_i),
    .mem_reg_write_en_i(mem_reg_write_en_i),
    .irq_i             (irq_i),
    .mret_i            (mret_i),
    .if_enable_o       (if_enable_o),
    .id_enable_o       (id_enable_o),
    .if_flush_n_o      (if_flush_n_o),
    .id_flush_n_o      (id_flush_n_o),
    .rs1_depended_o    (rs1_depended_o),
    .irq_redirect_o    (irq_redirect_o),
    .irq_target_o      (irq_target_o),
    .irq_ack_o         (irq_ack_o),
    .in_handler_o      (in_handler_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic ife, input logic ide, input logic iffn,
                              input logic idfn, input logic rs1d, input logic redir,
                              input logic [31:0] tgt, input logic ack, input logic inh);
    exp_t e;
    e.ife = ife; e.ide = ide; e.iffn = iffn; e.idfn = idfn; e.rs1d = rs1d;
    e.redir = redir; e.tgt = tgt; e.ack = ack; e.inh = inh;
    return e;
  endfunction

  task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, "if_enable",    {31'd0, if_enable_o},    {31'd0, e.ife});
    cmp(t, "id_enable",    {31'd0, id_enable_o},    {31'd0, e.ide});
    cmp(t, "if_flush_n",   {31'd0, if_flush_n_o},   {31'd0, e.iffn});
    cmp(t, "id_flush_n",   {31'd0, id_flush_n_o},   {31'd0, e.idfn});
    cmp(t, "rs1_depended", {31'd0, rs1_depended_o}, {31'd0, e.rs1d});
    cmp(t, "irq_redirect", {31'd0, irq_redirect_o}, {31'd0, e.redir});
    cmp(t, "irq_target",   irq_target_o,            e.tgt);
    cmp(t, "irq_ack",      {31'd0, irq_ack_o},      {31'd0, e.ack});
    cmp(t, "in_handler",   {31'd0, in_handler_o},   {31'd0, e.inh});
  endtask

  // Inputs are already driven; check at the falling edge, then advance one cycle.
  task automatic step(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_idx_i = '0; id_rs2_idx_i = '0; id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    id_is_jalr_i = 0; id_pc_i = '0; id_taken_i = 0;
    ex_rd_idx_i = '0; ex_reg_write_en_i = 0; ex_is_load_i = 0;
    ex_mispredict_i = 0; ex_target_i = '0;
    mem_rd_idx_i = '0; mem_reg_write_en_i = 0; irq_i = 0; mret_i = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step("reset", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));
    reset = 1'b0;

    // Load-use: lw x5 in EXE, add reading x5 via rs2 in ID.
    ex_rd_idx_i = 5'd5; ex_is_load_i = 1; ex_reg_write_en_i = 1;
    id_rs2_idx_i = 5'd5; id_uses_rs2_i = 1;
    step("load_use", mk(0, 1, 1, 0, 0, 0, 32'h0, 0, 0));
    clear_inputs();
    step("after_load_use", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));

    // Loads to x0 never stall.
    ex_rd_idx_i = 5'd0; ex_is_load_i = 1; ex_reg_write_en_i = 1;
    id_uses_rs1_i = 1; id_uses_rs2_i = 1;
    step("rd_zero", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));
    clear_inputs();

    // jalr rs1 produced by MEM: dependency flagged, no stall.
    id_is_jalr_i = 1; id_uses_rs1_i = 1; id_rs1_idx_i = 5'd7;
    mem_rd_idx_i = 5'd7; mem_reg_write_en_i = 1;
    step("jalr_mem_dep", mk(1, 1, 1, 1, 1, 0, 32'h0, 0, 0));
    clear_inputs();

    // Mispredict outranks the load-use stall.
    ex_mispredict_i = 1; ex_target_i = 32'h44;
    ex_rd_idx_i = 5'd5; ex_is_load_i = 1; ex_reg_write_en_i = 1;
    id_rs2_idx_i = 5'd5; id_uses_rs2_i = 1;
    step("mispredict_and_load_use", mk(1, 1, 0, 0, 0, 0, 32'h0, 0, 0));
    clear_inputs();

    id_taken_i = 1;
    step("id_taken", mk(1, 1, 0, 1, 0, 0, 32'h0, 0, 0));
    clear_inputs();

    // jalr waiting on a load in EXE stalls even without a uses_rs1 flag.
    id_is_jalr_i = 1; id_rs1_idx_i = 5'd9;
    ex_rd_idx_i = 5'd9; ex_is_load_i = 1; ex_reg_write_en_i = 1;
    step("jalr_stall", mk(0, 1, 1, 0, 1, 0, 32'h0, 0, 0));
    clear_inputs();

    // Interrupt entry at pc 0x40, with irq dropped during drain.
    irq_i = 1; id_pc_i = 32'h40;
    step("irq_accept", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));
    clear_inputs();
    step("drain1", mk(0, 1, 0, 0, 0, 0, 32'h0, 0, 0));
    ex_mispredict_i = 1; ex_target_i = 32'h80;
    step("drain2_mispredict", mk(1, 1, 0, 0, 0, 0, 32'h0, 0, 0));
    clear_inputs();
    step("vector", mk(1, 1, 0, 1, 0, 1, 32'h100, 1, 0));

    // Handler ignores a second irq; mret waits out a stall.
    irq_i = 1;
    step("handler_irq_ignored", mk(1, 1, 1, 1, 0, 0, 32'h100, 0, 1));
    mret_i = 1; ex_rd_idx_i = 5'd3; ex_is_load_i = 1; ex_reg_write_en_i = 1;
    id_rs1_idx_i = 5'd3; id_uses_rs1_i = 1;
    step("handler_mret_stalled", mk(0, 1, 1, 0, 0, 0, 32'h100, 0, 1));
    clear_inputs();
    irq_i = 1; mret_i = 1;
    step("handler_mret", mk(1, 1, 1, 1, 0, 0, 32'h100, 0, 1));
    mret_i = 0;
    step("return", mk(1, 1, 0, 0, 0, 1, 32'h80, 0, 0));
    clear_inputs();
    step("run_after_return", mk(1, 1, 1, 1, 0, 0, 32'h80, 0, 0));

    // Reset in the middle of drain discards everything.
    irq_i = 1; id_pc_i = 32'h200;
    step("irq_accept2", mk(1, 1, 1, 1, 0, 0, 32'h80, 0, 0));
    clear_inputs();
    step("drain_again", mk(0, 1, 0, 0, 0, 0, 32'h80, 0, 0));
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));
    tag_q.push_back("async_reset");
    check_now();
    step("reset_held", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));
    reset = 1'b0;
    step("post_reset1", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));
    step("post_reset2", mk(1, 1, 1, 1, 0, 0, 32'h0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
